sound_frame_sequencer: RTL and testbench
========================================

// Module: sound_frame_sequencer
// PURPOSE
//  Shared timing/length controller for APU channels 1-4. Divides the 33 MHz system clock into the
//  512 Hz frame sequencer, issues one-cycle length (256 Hz), sweep (128 Hz) and envelope (64 Hz) ticks
//  to all channels, and owns the four length counters plus the per-channel ON status read via NR52.
//  Sits between the NRxx register parsers and the channel datapaths.
// PARAMETERS
//  CLKS_PER_STEP  64453  system clocks per sequencer step (33 MHz / 512)
//  LEN_MAX_SQ     64     length reload value for channels 0, 1, 3 when triggered with counter==0
//  LEN_MAX_WAVE   256    length reload value for channel 2 (wave)
// PORTS
//  I_CLK         in   1   system clock, 33 MHz
//  I_RESET       in   1   synchronous reset, active high
//  I_MASTER_EN   in   1   NR52 bit 7; 0 = APU powered off
//  I_TRIGGER     in   4   per-channel one-cycle pulse: NRx4 write with bit 7 set
//  I_LEN_EN      in   4   per-channel NRx4 bit 6 (length counting enabled)
//  I_LEN_LOAD    in   4   per-channel one-cycle pulse: length register written
//  I_LEN_INIT    in   36  per-channel 9-bit load value ({ch3,ch2,ch1,ch0}); already 64-x / 256-x
//  I_DAC_ON      in   4   per-channel DAC enable (NRx2[7:3]!=0; NR30 bit 7 for ch2)
//  O_STEP        out  3   current sequencer step, 0..7
//  O_LEN_TICK    out  1   one-cycle pulse, length clock
//  O_SWEEP_TICK  out  1   one-cycle pulse, sweep clock (channel 0 only consumes it)
//  O_ENV_TICK    out  1   one-cycle pulse, envelope clock
//  O_CH_ON       out  4   per-channel active status (NR52 bits 3:0, channel enable)
//  O_CH_KILL     out  4   one-cycle pulse: channel stopped by length expiry
// BEHAVIOUR
//  Reset: prescaler=0, O_STEP=0, all ticks 0, O_CH_ON=0, O_CH_KILL=0, all length counters=0.
//  Prescaler: counts 0..CLKS_PER_STEP-1 while I_MASTER_EN=1, wraps to 0.
//  Step execution: in the cycle the prescaler equals CLKS_PER_STEP-1, step s executes:
//   - next cycle O_LEN_TICK=1 if s is even; O_SWEEP_TICK=1 if s is 2 or 6; O_ENV_TICK=1 if s==7
//   - O_STEP <= (s+1) mod 8, updated in the same cycle the ticks appear; 7 wraps to 0
//   - all tick outputs are registered, 1-cycle latency, high exactly one cycle
//  Length counter i (9 bits), priority high to low, evaluated each cycle:
//   1. I_LEN_LOAD[i]: counter <= I_LEN_INIT[9i+8:9i]. Status is unchanged.
//   2. I_TRIGGER[i]: O_CH_ON[i] <= I_DAC_ON[i]. If counter==0, counter <= LEN_MAX (64 or 256).
//      No decrement in the trigger cycle, even if a length tick coincides.
//   3. Length tick (internal, the cycle O_LEN_TICK is driven), I_LEN_EN[i]=1, counter!=0:
//      counter - 1. At the 1->0 transition, O_CH_ON[i] <= 0 and O_CH_KILL[i]=1 for one cycle.
//   - Load and trigger in the same cycle: the loaded value is used for the ==0 check of the trigger.
//   - counter==0 with a tick: no wrap and no kill pulse.
//  DAC: while I_DAC_ON[i]=0, O_CH_ON[i] is forced 0 the next cycle; no kill pulse.
//  Master off (I_MASTER_EN=0): the next cycle forces prescaler=0, O_STEP=0, ticks=0, O_CH_ON=0.
//   Length counters hold their values. Triggers are ignored while off. On re-enable, step 0
//   executes after a full CLKS_PER_STEP.
//  Mid-operation I_RESET overrides everything in the same edge, including pending ticks.
//  Arithmetic: the prescaler is $clog2(CLKS_PER_STEP) bits, unsigned. No counter exceeds its range.
// STRUCTURE
//  Shared package sound_pkg: CLKS_PER_STEP, LEN_MAX_SQ, LEN_MAX_WAVE, step masks
//   (LEN_STEPS=8'b0101_0101, SWEEP_STEPS=8'b0100_0100, ENV_STEPS=8'b1000_0000), channel indices.
//  One sub-module, sound_length_counter (9-bit counter, load/trigger/tick, ON flag, kill pulse),
//   instantiated 4x with LEN_MAX passed per instance. The prescaler and step logic stay at the top level.
// TESTING  (bench uses CLKS_PER_STEP=4)
//  Free run 32 steps from reset: length ticks after steps 0,2,4,6; sweep ticks after 2,6;
//   envelope tick after 7; each tick 1 cycle wide; O_STEP sequence 1,2,..7,0.
//  ch0: load 3, LEN_EN=1, trigger with DAC on -> O_CH_ON[0]=1; after 3 length ticks
//   O_CH_ON[0]=0 and one O_CH_KILL[0] pulse; further ticks produce no kill.
//  ch2: trigger with counter=0 -> reload 256; LEN_EN=0 for 10 ticks gives no change;
//   LEN_EN=1 and 256 ticks -> kill.
//  Trigger in the same cycle as a length tick, counter=5 -> counter stays 5, ON=1.
//   Load 7 plus trigger in the same cycle -> counter 7.
//  Drop I_MASTER_EN mid-step at step 5 -> next cycle step=0, O_CH_ON=0, counters held;
//   a trigger while off is ignored; re-enable -> first tick after 4 clocks.
//  DAC off while ON -> O_CH_ON=0 the next cycle with no kill. Trigger with DAC off -> stays 0.
//   I_RESET during a tick cycle -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and types for the APU frame sequencer and its length counters.
package sound_pkg;

  localparam int unsigned CLKS_PER_STEP = 64453;
  localparam int unsigned LEN_MAX_SQ    = 64;
  localparam int unsigned LEN_MAX_WAVE  = 256;
  localparam int unsigned NUM_CH        = 4;
  localparam int unsigned LEN_W         = 9;
  localparam int unsigned STEP_W        = 3;

  // Bit s set: step s issues that tick.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  typedef enum logic [1:0] {
    CH_SQ1   = 2'd0,
    CH_SQ2   = 2'd1,
    CH_WAVE  = 2'd2,
    CH_NOISE = 2'd3
  } ch_idx_e;

  typedef struct packed {
    logic env;
    logic sweep;
    logic len;
  } seq_tick_t;

  function automatic int unsigned len_max_for(input int unsigned ch);
    return (ch == int'(CH_WAVE)) ? LEN_MAX_WAVE : LEN_MAX_SQ;
  endfunction

endpackage

// File: rtl/sound_frame_sequencer_if.sv
// Register-parser side <-> frame sequencer signal bundle.
interface sound_frame_sequencer_if;
  import sound_pkg::*;

  logic                    I_MASTER_EN;
  logic [NUM_CH-1:0]       I_TRIGGER;
  logic [NUM_CH-1:0]       I_LEN_EN;
  logic [NUM_CH-1:0]       I_LEN_LOAD;
  logic [NUM_CH*LEN_W-1:0] I_LEN_INIT;
  logic [NUM_CH-1:0]       I_DAC_ON;
  logic [STEP_W-1:0]       O_STEP;
  logic                    O_LEN_TICK;
  logic                    O_SWEEP_TICK;
  logic                    O_ENV_TICK;
  logic [NUM_CH-1:0]       O_CH_ON;
  logic [NUM_CH-1:0]       O_CH_KILL;

  modport master (
    output I_MASTER_EN, I_TRIGGER, I_LEN_EN, I_LEN_LOAD, I_LEN_INIT, I_DAC_ON,
    input  O_STEP, O_LEN_TICK, O_SWEEP_TICK, O_ENV_TICK, O_CH_ON, O_CH_KILL
  );

  modport slave (
    input  I_MASTER_EN, I_TRIGGER, I_LEN_EN, I_LEN_LOAD, I_LEN_INIT, I_DAC_ON,
    output O_STEP, O_LEN_TICK, O_SWEEP_TICK, O_ENV_TICK, O_CH_ON, O_CH_KILL
  );

endinterface

// File: rtl/sound_length_counter.sv
// One channel's 9-bit length counter with its ON status and expiry pulse.
module sound_length_counter
  import sound_pkg::*;
#(
  parameter int unsigned LEN_MAX = LEN_MAX_SQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             master_en,
  input  logic             trigger,
  input  logic             len_en,
  input  logic             len_load,
  input  logic [LEN_W-1:0] len_init,
  input  logic             dac_on,
  input  logic             tick,
  output logic             ch_on,
  output logic             ch_kill
);

  localparam logic [LEN_W-1:0] RELOAD = LEN_W'(LEN_MAX);

  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] cnt_eff_c;
  logic             dec_c;
  logic             expire_c;

  // A same-cycle load feeds the trigger's empty check; load or trigger blocks the decrement.
  always_comb begin
    cnt_eff_c = len_load ? len_init : cnt_q;
    dec_c     = tick && len_en && !len_load && !trigger && (cnt_q != '0);
    expire_c  = dec_c && (cnt_q == LEN_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      ch_on   <= 1'b0;
      ch_kill <= 1'b0;
    end else begin
      ch_kill <= 1'b0;
      if (!master_en) begin
        ch_on <= 1'b0;
      end else begin
        if (trigger)       cnt_q <= (cnt_eff_c == '0) ? RELOAD : cnt_eff_c;
        else if (len_load) cnt_q <= len_init;
        else if (dec_c)    cnt_q <= cnt_q - LEN_W'(1);

        if (!dac_on)       ch_on <= 1'b0;
        else if (trigger)  ch_on <= 1'b1;
        else if (expire_c) ch_on <= 1'b0;

        if (expire_c) ch_kill <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer: prescaler, step counter, tick generation and four length counters.
module sound_frame_sequencer
  import sound_pkg::NUM_CH, sound_pkg::LEN_W, sound_pkg::STEP_W, sound_pkg::seq_tick_t;
#(
  parameter int unsigned CLKS_PER_STEP = sound_pkg::CLKS_PER_STEP
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  sound_frame_sequencer_if.slave  bus
);

  localparam int unsigned PRE_W = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_STEP - 1);

  logic [PRE_W-1:0]  prescaler_q;
  logic [STEP_W-1:0] step_q;
  seq_tick_t         tick_q;
  logic              step_exec_c;
  logic [NUM_CH-1:0] ch_on_w;
  logic [NUM_CH-1:0] ch_kill_w;

  assign step_exec_c = (prescaler_q == PRE_LAST);

  // The step that runs this cycle picks the ticks that appear with the advanced step next cycle.
  always_ff @(posedge I_CLK) begin
    if (I_RESET || !bus.I_MASTER_EN) begin
      prescaler_q <= '0;
      step_q      <= '0;
      tick_q      <= '0;
    end else begin
      tick_q <= '0;
      if (step_exec_c) begin
        prescaler_q  <= '0;
        step_q       <= step_q + STEP_W'(1);
        tick_q.len   <= sound_pkg::LEN_STEPS[step_q];
        tick_q.sweep <= sound_pkg::SWEEP_STEPS[step_q];
        tick_q.env   <= sound_pkg::ENV_STEPS[step_q];
      end else begin
        prescaler_q <= prescaler_q + PRE_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_len
    localparam int unsigned LMAX = sound_pkg::len_max_for(i);

    sound_length_counter #(
      .LEN_MAX (LMAX)
    ) u_len (
      .clk       (I_CLK),
      .rst       (I_RESET),
      .master_en (bus.I_MASTER_EN),
      .trigger   (bus.I_TRIGGER[i]),
      .len_en    (bus.I_LEN_EN[i]),
      .len_load  (bus.I_LEN_LOAD[i]),
      .len_init  (bus.I_LEN_INIT[i*LEN_W +: LEN_W]),
      .dac_on    (bus.I_DAC_ON[i]),
      .tick      (tick_q.len),
      .ch_on     (ch_on_w[i]),
      .ch_kill   (ch_kill_w[i])
    );
  end

  assign bus.O_STEP       = step_q;
  assign bus.O_LEN_TICK   = tick_q.len;
  assign bus.O_SWEEP_TICK = tick_q.sweep;
  assign bus.O_ENV_TICK   = tick_q.env;
  assign bus.O_CH_ON      = ch_on_w;
  assign bus.O_CH_KILL    = ch_kill_w;

endmodule

// File: tb/tb_sound_frame_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_sound_frame_sequencer;
  import sound_pkg::*;

  localparam int unsigned CPS = 4;

  logic clk;
  logic rst;

  sound_frame_sequencer_if bus ();

  sound_frame_sequencer #(.CLKS_PER_STEP(CPS)) dut (
    .I_CLK   (clk),
    .I_RESET (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Inputs for the next cycle, applied at the falling edge.
  logic        p_rst, p_men;
  logic [3:0]  p_len_en, p_dac, p_trig, p_load;
  logic [35:0] p_init;

  // Reference model state: outputs expected after the latest rising edge.
  int          m_en_cnt;
  int          m_step;
  logic        m_len, m_sweep, m_env;
  logic [3:0]  m_on, m_kill;
  int          m_cnt [4];

  // Observations taken at the falling edge.
  int          obs_len, obs_sweep, obs_env;
  int          obs_kill [4];
  logic [2:0]  s_step;
  logic        s_len;
  logic [3:0]  s_on;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int len_max(input int ch);
    return (ch == int'(CH_WAVE)) ? int'(LEN_MAX_WAVE) : int'(LEN_MAX_SQ);
  endfunction

  // Model: steps fire every CPS enabled edges since the last restart; length rules by priority.
  task automatic model_update();
    logic tick_now;
    int   s;
    int   cnt_src;
    tick_now = m_len;
    if (rst === 1'b1 || bus.I_MASTER_EN !== 1'b1) begin
      m_en_cnt = 0;
      m_step   = 0;
      m_len    = 1'b0;
      m_sweep  = 1'b0;
      m_env    = 1'b0;
      m_on     = '0;
      m_kill   = '0;
      if (rst === 1'b1) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      m_kill = '0;
      for (int i = 0; i < 4; i++) begin
        cnt_src = bus.I_LEN_LOAD[i] ? int'(bus.I_LEN_INIT[9*i +: 9]) : m_cnt[i];
        if (bus.I_LEN_LOAD[i]) m_cnt[i] = cnt_src;
        if (bus.I_TRIGGER[i]) begin
          m_on[i] = bus.I_DAC_ON[i];
          if (cnt_src == 0) m_cnt[i] = len_max(i);
        end else if (!bus.I_LEN_LOAD[i] && tick_now && bus.I_LEN_EN[i] && m_cnt[i] != 0) begin
          m_cnt[i] = m_cnt[i] - 1;
          if (m_cnt[i] == 0) begin
            m_on[i]   = 1'b0;
            m_kill[i] = 1'b1;
          end
        end
        if (!bus.I_DAC_ON[i]) m_on[i] = 1'b0;
      end
      m_en_cnt++;
      if (m_en_cnt % CPS == 0) begin
        s       = (m_en_cnt / CPS - 1) % 8;
        m_len   = (s % 2 == 0);
        m_sweep = (s == 2 || s == 6);
        m_env   = (s == 7);
        m_step  = (m_en_cnt / CPS) % 8;
      end else begin
        m_len   = 1'b0;
        m_sweep = 1'b0;
        m_env   = 1'b0;
      end
    end
  endtask

  // One clock: compare at the falling edge, drive pending inputs, advance the model at the rising edge.
  task automatic cyc();
    @(negedge clk);
    s_step = bus.O_STEP;
    s_len  = bus.O_LEN_TICK;
    s_on   = bus.O_CH_ON;
    check("step",       32'(bus.O_STEP),       32'(m_step));
    check("len_tick",   32'(bus.O_LEN_TICK),   32'(m_len));
    check("sweep_tick", 32'(bus.O_SWEEP_TICK), 32'(m_sweep));
    check("env_tick",   32'(bus.O_ENV_TICK),   32'(m_env));
    check("ch_on",      32'(bus.O_CH_ON),      32'(m_on));
    check("ch_kill",    32'(bus.O_CH_KILL),    32'(m_kill));
    if (bus.O_LEN_TICK === 1'b1)   obs_len++;
    if (bus.O_SWEEP_TICK === 1'b1) obs_sweep++;
    if (bus.O_ENV_TICK === 1'b1)   obs_env++;
    for (int i = 0; i < 4; i++) if (bus.O_CH_KILL[i] === 1'b1) obs_kill[i]++;
    rst             = p_rst;
    bus.I_MASTER_EN = p_men;
    bus.I_LEN_EN    = p_len_en;
    bus.I_DAC_ON    = p_dac;
    bus.I_LEN_INIT  = p_init;
    bus.I_TRIGGER   = p_trig;
    bus.I_LEN_LOAD  = p_load;
    p_trig = '0;
    p_load = '0;
    @(posedge clk);
    model_update();
  endtask

  task automatic run_ticks(input int n);
    int target;
    int budget;
    target = obs_len + n;
    budget = (n + 1) * 2 * int'(CPS) + 2;
    while (obs_len < target && budget > 0) begin
      cyc();
      budget--;
    end
    if (obs_len < target) check("run_ticks_timeout", 32'(obs_len), 32'(target));
  endtask

  // Stop when the cycle about to be driven carries a length tick.
  task automatic wait_tick_next();
    int budget;
    budget = 4 * int'(CPS) + 2;
    while (!m_len && budget > 0) begin
      cyc();
      budget--;
    end
    if (!m_len) check("wait_tick_timeout", 32'(m_len), 32'd1);
  endtask

  initial begin
    int n;
    p_rst = 1'b1; p_men = 1'b0; p_len_en = '0; p_dac = '0;
    p_trig = '0; p_load = '0; p_init = '0;
    obs_len = 0; obs_sweep = 0; obs_env = 0;
    for (int i = 0; i < 4; i++) obs_kill[i] = 0;
    rst = 1'b1;
    bus.I_MASTER_EN = 1'b0; bus.I_LEN_EN = '0; bus.I_DAC_ON = '0;
    bus.I_LEN_INIT = '0; bus.I_TRIGGER = '0; bus.I_LEN_LOAD = '0;
    @(posedge clk);
    model_update();

    // Reset state, then 32 free-running steps.
    p_men = 1'b1;
    p_dac = 4'hF;
    cyc();
    p_rst = 1'b0;
    obs_len = 0; obs_sweep = 0; obs_env = 0;
    repeat (32 * CPS + 1) cyc();
    check("free_len_count",   32'(obs_len),   32'd16);
    check("free_sweep_count", 32'(obs_sweep), 32'd8);
    check("free_env_count",   32'(obs_env),   32'd4);

    // ch0: load 3, trigger, expires after 3 ticks, no further kills.
    p_len_en[0] = 1'b1; p_init[8:0] = 9'd3; p_load = 4'b0001;
    cyc();
    obs_kill[0] = 0;
    p_trig = 4'b0001;
    cyc();
    cyc();
    check("ch0_on_after_trig", 32'(s_on[0]), 32'd1);
    run_ticks(3);
    cyc();
    cyc();
    check("ch0_off_after_3", 32'(s_on[0]), 32'd0);
    check("ch0_kill_once",   32'(obs_kill[0]), 32'd1);
    run_ticks(4);
    check("ch0_no_more_kill", 32'(obs_kill[0]), 32'd1);

    // ch2: empty counter reloads 256; held while length disabled, then 256 ticks to kill.
    obs_kill[2] = 0;
    p_trig = 4'b0100;
    cyc();
    run_ticks(10);
    cyc();
    check("ch2_on_len_dis", 32'(s_on[2]), 32'd1);
    p_len_en[2] = 1'b1;
    run_ticks(255);
    cyc();
    check("ch2_on_at_255",  32'(s_on[2]), 32'd1);
    check("ch2_no_kill_255", 32'(obs_kill[2]), 32'd0);
    run_ticks(1);
    cyc();
    cyc();
    check("ch2_kill_256", 32'(obs_kill[2]), 32'd1);
    check("ch2_off_256",  32'(s_on[2]), 32'd0);

    // ch1: trigger coincides with a length tick, counter 5 survives it.
    p_len_en[1] = 1'b1; p_init[17:9] = 9'd5; p_load = 4'b0010;
    cyc();
    obs_kill[1] = 0;
    wait_tick_next();
    p_trig = 4'b0010;
    cyc();
    run_ticks(4);
    cyc();
    check("ch1_on_after_4", 32'(s_on[1]), 32'd1);
    check("ch1_no_kill_4",  32'(obs_kill[1]), 32'd0);
    run_ticks(1);
    cyc();
    cyc();
    check("ch1_kill_5", 32'(obs_kill[1]), 32'd1);

    // ch3: load 7 and trigger together -> 7 ticks, not 64.
    p_len_en[3] = 1'b1; p_init[35:27] = 9'd7; p_load = 4'b1000; p_trig = 4'b1000;
    obs_kill[3] = 0;
    cyc();
    run_ticks(6);
    cyc();
    check("ch3_on_after_6", 32'(s_on[3]), 32'd1);
    run_ticks(1);
    cyc();
    cyc();
    check("ch3_kill_7", 32'(obs_kill[3]), 32'd1);

    // Master off mid step 5, trigger ignored while off, re-enable timing.
    p_init[8:0] = 9'd20; p_load = 4'b0001; p_trig = 4'b0001;
    cyc();
    n = 0;
    while (m_step != 5 && n < 16 * int'(CPS)) begin cyc(); n++; end
    check("reach_step5", 32'(m_step), 32'd5);
    cyc();
    p_men = 1'b0;
    cyc();
    cyc();
    check("off_step", 32'(s_step), 32'd0);
    check("off_on",   32'(s_on),   32'd0);
    p_trig = 4'b0001;
    cyc();
    cyc();
    check("off_trig_ignored", 32'(s_on), 32'd0);
    p_men = 1'b1;
    cyc();
    n = 0;
    do begin cyc(); n++; end while (!s_len && n < 3 * int'(CPS));
    check("reenable_tick_delay", 32'(n), 32'(CPS));
    p_trig = 4'b0001;
    cyc();
    cyc();
    check("held_cnt_on", 32'(s_on[0]), 32'd1);

    // DAC off forces ON low without a kill; trigger with DAC off stays low.
    obs_kill[0] = 0;
    p_dac[0] = 1'b0;
    cyc();
    cyc();
    check("dac_off_on",   32'(s_on[0]), 32'd0);
    check("dac_off_kill", 32'(obs_kill[0]), 32'd0);
    p_trig = 4'b0001;
    cyc();
    cyc();
    check("dac_off_trig", 32'(s_on[0]), 32'd0);
    p_dac[0] = 1'b1;

    // Reset landing on a tick cycle.
    p_trig = 4'b0010;
    cyc();
    wait_tick_next();
    p_rst = 1'b1;
    cyc();
    p_rst = 1'b0;
    cyc();
    check("rst_tick_step", 32'(s_step), 32'd0);
    check("rst_tick_len",  32'(s_len),  32'd0);
    check("rst_tick_on",   32'(s_on),   32'd0);

    // Random traffic.
    for (int k = 0; k < 1200; k++) begin
      if ($urandom_range(0, 149) == 0) p_men = ~p_men;
      p_rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < 4; i++) begin
        p_dac[i] = ($urandom_range(0, 19) != 0);
        if ($urandom_range(0, 49) == 0) p_len_en[i] = ~p_len_en[i];
        if (p_men) begin
          p_trig[i] = ($urandom_range(0, 29) == 0);
          if ($urandom_range(0, 29) == 0) begin
            p_load[i] = 1'b1;
            p_init[9*i +: 9] = 9'($urandom_range(0, 12));
          end
        end
      end
      cyc();
    end
    p_men = 1'b1;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
